// File: rtl/sort_12_frame_loader.sv
// Gathers a serial 32-bit word stream into a 12-lane frame for the sorting network; short frames pad with PAD.
// Define SORT12_LOADER_PINGPONG_EN for a double-buffered build that fills one frame while presenting the other.
module sort_12_frame_loader #(
  parameter int unsigned LANES = 12,
  parameter logic [31:0] PAD   = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_data,
  input  logic        in_last,
  output logic        frame_valid,
  input  logic        frame_ready,
  output logic [31:0] data_0,
  output logic [31:0] data_1,
  output logic [31:0] data_2,
  output logic [31:0] data_3,
  output logic [31:0] data_4,
  output logic [31:0] data_5,
  output logic [31:0] data_6,
  output logic [31:0] data_7,
  output logic [31:0] data_8,
  output logic [31:0] data_9,
  output logic [31:0] data_10,
  output logic [31:0] data_11,
  output logic [3:0]  frame_count
);

  typedef enum logic {FILL, HOLD} buf_state_t;

  logic [31:0] lane_q [LANES];
  logic [3:0]  idx;
  logic        word_acc;
  logic        closing;

  assign word_acc = in_valid && in_ready;
  assign closing  = in_last || (idx == 4'(LANES - 1));

`ifdef SORT12_LOADER_PINGPONG_EN
  buf_state_t  st    [2];
  logic [31:0] lanes [2][LANES];
  logic [3:0]  cnt   [2];
  logic        wsel;
  logic        rsel;

  // Fill and present pointers alternate strictly, so the fill buffer is only
  // ever in HOLD when both buffers hold frames.
  assign in_ready    = (st[wsel] == FILL) && !rst;
  assign frame_valid = (st[rsel] == HOLD);
  assign frame_count = cnt[rsel];

  always_comb begin
    for (int unsigned k = 0; k < LANES; k++) lane_q[k] = lanes[rsel][k];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned b = 0; b < 2; b++) begin
        st[b]  <= FILL;
        cnt[b] <= '0;
        for (int unsigned k = 0; k < LANES; k++) lanes[b][k] <= PAD;
      end
      wsel <= 1'b0;
      rsel <= 1'b0;
      idx  <= '0;
    end else begin
      // Release and close touch different buffers, so both may happen in one cycle.
      if (frame_valid && frame_ready) begin
        st[rsel]  <= FILL;
        cnt[rsel] <= '0;
        for (int unsigned k = 0; k < LANES; k++) lanes[rsel][k] <= PAD;
        rsel <= ~rsel;
      end
      if (word_acc) begin
        lanes[wsel][idx] <= in_data;
        if (closing) begin
          st[wsel]  <= HOLD;
          cnt[wsel] <= idx + 4'd1;
          idx       <= '0;
          wsel      <= ~wsel;
        end else begin
          idx <= idx + 4'd1;
        end
      end
    end
  end
`else
  buf_state_t  state;
  logic [3:0]  cnt;

  assign in_ready    = (state == FILL) && !rst;
  assign frame_valid = (state == HOLD);
  assign frame_count = cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FILL;
      cnt   <= '0;
      idx   <= '0;
      for (int unsigned k = 0; k < LANES; k++) lane_q[k] <= PAD;
    end else begin
      case (state)
        FILL: begin
          if (word_acc) begin
            lane_q[idx] <= in_data;
            if (closing) begin
              state <= HOLD;
              cnt   <= idx + 4'd1;
              idx   <= '0;
            end else begin
              idx <= idx + 4'd1;
            end
          end
        end
        HOLD: begin
          if (frame_ready) begin
            state <= FILL;
            cnt   <= '0;
            for (int unsigned k = 0; k < LANES; k++) lane_q[k] <= PAD;
          end
        end
        default: state <= FILL;
      endcase
    end
  end
`endif

  assign data_0  = lane_q[0];
  assign data_1  = lane_q[1];
  assign data_2  = lane_q[2];
  assign data_3  = lane_q[3];
  assign data_4  = lane_q[4];
  assign data_5  = lane_q[5];
  assign data_6  = lane_q[6];
  assign data_7  = lane_q[7];
  assign data_8  = lane_q[8];
  assign data_9  = lane_q[9];
  assign data_10 = lane_q[10];
  assign data_11 = lane_q[11];

endmodule

// File: tb/tb_sort_12_frame_loader.sv
// Self-checking bench for sort_12_frame_loader: directed test-plan steps then random traffic,
// checked against a queue-of-frames reference model.
module tb_sort_12_frame_loader;

  localparam logic [31:0] PAD = 32'hFFFF_FFFF;
`ifdef SORT12_LOADER_PINGPONG_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif

  typedef logic [12*32-1:0] frame_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_data = '0;
  logic        in_last = 1'b0;
  logic        frame_valid;
  logic        frame_ready = 1'b0;
  logic [31:0] data_0, data_1, data_2, data_3, data_4, data_5;
  logic [31:0] data_6, data_7, data_8, data_9, data_10, data_11;
  logic [3:0]  frame_count;
  logic [31:0] lane [12];

  int checks = 0;
  int errors = 0;

  logic [31:0] cur_words [$];
  frame_t      exp_frames [$];
  int          exp_cnt [$];
  bit          last_acc;

  always #5 clk = ~clk;

  sort_12_frame_loader dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .frame_valid(frame_valid), .frame_ready(frame_ready),
    .data_0(data_0), .data_1(data_1), .data_2(data_2), .data_3(data_3),
    .data_4(data_4), .data_5(data_5), .data_6(data_6), .data_7(data_7),
    .data_8(data_8), .data_9(data_9), .data_10(data_10), .data_11(data_11),
    .frame_count(frame_count)
  );

  assign lane[0]  = data_0;
  assign lane[1]  = data_1;
  assign lane[2]  = data_2;
  assign lane[3]  = data_3;
  assign lane[4]  = data_4;
  assign lane[5]  = data_5;
  assign lane[6]  = data_6;
  assign lane[7]  = data_7;
  assign lane[8]  = data_8;
  assign lane[9]  = data_9;
  assign lane[10] = data_10;
  assign lane[11] = data_11;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // One clock: drive inputs, check in_ready before the edge, update the model, check outputs after.
  task automatic step(input bit r, input bit v, input logic [31:0] d, input bit l, input bit fr);
    bit     exp_ready, acc_w, acc_f;
    frame_t f;
    rst = r; in_valid = v; in_data = d; in_last = l; frame_ready = fr;
    #1;
    exp_ready = !r && (exp_frames.size() < DEPTH);
    chk("in_ready", {31'b0, in_ready}, {31'b0, exp_ready});
    acc_w = v && exp_ready;
    acc_f = !r && fr && (exp_frames.size() != 0);
    @(posedge clk);
    #1;
    if (r) begin
      cur_words.delete();
      exp_frames.delete();
      exp_cnt.delete();
    end else begin
      if (acc_f) begin
        void'(exp_frames.pop_front());
        void'(exp_cnt.pop_front());
      end
      if (acc_w) begin
        cur_words.push_back(d);
        if (l || cur_words.size() == 12) begin
          f = '1;
          for (int i = 0; i < cur_words.size(); i++) f[i*32 +: 32] = cur_words[i];
          exp_frames.push_back(f);
          exp_cnt.push_back(cur_words.size());
          cur_words.delete();
        end
      end
    end
    last_acc = acc_w;
    chk("frame_valid", {31'b0, frame_valid}, {31'b0, exp_frames.size() != 0});
    if (exp_frames.size() != 0) begin
      f = exp_frames[0];
      chk("frame_count", {28'b0, frame_count}, 32'(exp_cnt[0]));
      for (int k = 0; k < 12; k++) chk($sformatf("data_%0d", k), lane[k], f[k*32 +: 32]);
    end else if (r) begin
      chk("reset_count", {28'b0, frame_count}, 32'd0);
      for (int k = 0; k < 12; k++) chk($sformatf("reset_data_%0d", k), lane[k], PAD);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input bit l, input bit fr);
    int tries = 0;
    do begin
      step(1'b0, 1'b1, d, l, fr);
      tries++;
    end while (!last_acc && tries < 40);
    if (!last_acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);
    step(1'b1, 1'b0, '0, 1'b0, 1'b0);

    // Full frame, values 12 down to 1, consumer always ready.
    for (int i = 0; i < 12; i++) send_word(32'(12 - i), 1'b0, 1'b1);
    for (int i = 0; i < 2; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Short frame of five words, then a single-word frame.
    for (int i = 0; i < 5; i++) send_word(32'hA + 32'(i), i == 4, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
    send_word(32'h5, 1'b1, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Backpressure: close a frame, hold frame_ready low for 10 cycles with words offered.
    for (int i = 0; i < 12; i++) send_word(32'h100 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 32'h200 + 32'(i), 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    // Reset mid-fill, then a fresh three-word frame.
    for (int i = 0; i < 7; i++) send_word(32'h300 + 32'(i), 1'b0, 1'b1);
    step(1'b1, 1'b0, '0, 1'b0, 1'b1);
    for (int i = 0; i < 3; i++) send_word(32'h400 + 32'(i), i == 2, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);

`ifdef SORT12_LOADER_PINGPONG_EN
    // Back-to-back frames with continuous valid and ready.
    for (int i = 0; i < 36; i++) step(1'b0, 1'b1, 32'h500 + 32'(i), 1'b0, 1'b1);
    step(1'b0, 1'b0, '0, 1'b0, 1'b1);
`endif

    // Random traffic including occasional resets and long/short frames.
    for (int i = 0; i < 600; i++)
      step($urandom_range(99) == 0, $urandom_range(3) != 0, $urandom,
           $urandom_range(7) == 0, $urandom_range(9) < 7);
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, '0, 1'b0, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
